// File: rtl/act_dispatch_pkg.sv
// Shared encodings and Q5.10 constants for the activation dispatcher.
// Q5.10 two's complement: 1.0 == 16'h0400.
package act_dispatch_pkg;

    localparam logic [1:0] SEL_SIGMOID = 2'b00;
    localparam logic [1:0] SEL_TANH    = 2'b01;
    localparam logic [1:0] SEL_RELU    = 2'b10;
    localparam logic [1:0] SEL_PASS    = 2'b11;

    localparam logic [15:0] ONE     = 16'h0400;
    localparam logic [15:0] NEG_ONE = 16'hFC00;
    localparam logic [15:0] K_INV   = 16'h04D4;

    typedef enum logic [2:0] {
        StIdle,
        StSat,
        StIssue,
        StWait,
        StPush
    } state_e;

endpackage

// File: rtl/act_result_fifo.sv
// First-word fall-through result FIFO; read data is forced to zero while empty.
// Push and pop may happen in the same cycle.
module act_result_fifo #(
    parameter int unsigned DW    = 21,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = DEPTH[CNTW-1:0];

    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CNTW-1:0] cnt_q;
    logic            do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/act_dispatch.sv
// Front end for the CORDIC activation unit: resolves relu/pass/saturated cases locally,
// issues in-range sigmoid/tanh over start/done, and queues results in accept order.
module act_dispatch #(
    parameter int unsigned    WIDTH   = 15,
    parameter int unsigned    TAG_W   = 4,
    parameter int unsigned    DEPTH   = 4,
    parameter logic [WIDTH:0] CLAMP   = 16'h0400,
    parameter logic [WIDTH:0] K_INV   = act_dispatch_pkg::K_INV,
    parameter int unsigned    TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             ext_reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_data,
    input  logic [1:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             act_start,
    output logic [WIDTH:0]   act_x,
    output logic [WIDTH:0]   act_y,
    output logic [WIDTH:0]   act_z,
    output logic [1:0]       act_sel,
    input  logic             act_done,
    input  logic [WIDTH:0]   act_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    import act_dispatch_pkg::*;

    localparam int unsigned W  = WIDTH + 1;
    localparam int unsigned DW = W + TAG_W + 1;
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WIDTH:0]   x_q, res_q, res_d, x_mag;
    logic [1:0]       sel_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, accept, push, act_busy;
    logic             fifo_full, fifo_empty;
    logic [DW-1:0]    fifo_rdata;

    // ready_q keeps in_ready low while reset is asserted and for the first clock after.
    assign in_ready = ready_q && (state_q == StIdle) && !fifo_full;
    assign accept   = in_valid && in_ready;
    // 16'h8000 negates to itself, which compares as a large unsigned magnitude.
    assign x_mag    = in_data[WIDTH] ? -in_data : in_data;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    err_d = 1'b0;
                    case (in_sel)
                        SEL_RELU: begin
                            res_d   = in_data[WIDTH] ? '0 : in_data;
                            state_d = StPush;
                        end
                        SEL_PASS: begin
                            res_d   = in_data;
                            state_d = StPush;
                        end
                        default: state_d = (x_mag > CLAMP) ? StSat : StIssue;
                    endcase
                end
            end
            StSat: begin
                if (sel_q == SEL_TANH) res_d = x_q[WIDTH] ? -W'(ONE) : W'(ONE);
                else                   res_d = x_q[WIDTH] ? '0 : W'(ONE);
                state_d = StPush;
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (act_done) begin
                    res_d   = act_result;
                    err_d   = 1'b0;
                    state_d = StPush;
                end else if (cnt_q == CNT_MAX) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = StPush;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StPush: begin
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            sel_q   <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
            if (accept) begin
                x_q   <= in_data;
                sel_q <= in_sel;
                tag_q <= in_tag;
            end
        end
    end

    // Seeds are held from ISSUE through the end of WAIT and read as zero otherwise.
    assign act_busy  = (state_q == StIssue) || (state_q == StWait);
    assign act_start = (state_q == StIssue);
    assign act_x     = act_busy ? K_INV : '0;
    assign act_y     = '0;
    assign act_z     = act_busy ? x_q : '0;
    assign act_sel   = act_busy ? sel_q : '0;

    act_result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (ext_reset_n),
        .push  (push),
        .wdata ({res_q, tag_q, err_q}),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign {out_data, out_tag, out_err} = fifo_rdata;

endmodule

// File: tb/tb_act_dispatch.sv
// Self-checking bench for act_dispatch: scenario tasks drive stimulus and check timing inline,
// a scoreboard checks every popped result against expectations queued at accept time.
module tb_act_dispatch;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        ext_reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [3:0]  in_tag = '0;
    logic        act_start;
    logic [15:0] act_x, act_y, act_z;
    logic [1:0]  act_sel;
    logic        act_done = 1'b0;
    logic [15:0] act_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_err;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   acc_cyc = 0;

    act_dispatch #(
        .WIDTH   (15),
        .TAG_W   (4),
        .DEPTH   (4),
        .CLAMP   (16'h0400),
        .K_INV   (16'h04D4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .ext_reset_n (ext_reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_tag      (in_tag),
        .act_start   (act_start),
        .act_x       (act_x),
        .act_y       (act_y),
        .act_z       (act_z),
        .act_sel     (act_sel),
        .act_done    (act_done),
        .act_result  (act_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (act_start) start_cnt++;

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (out_valid && out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got data=%h tag=%h err=%b, want no output",
                         out_data, out_tag, out_err);
            end else begin
                e = sb.pop_front();
                if ({out_data, out_tag, out_err} !== e)
                    $display("FAIL sb_result: got data=%h tag=%h err=%b, want data=%h tag=%h err=%b",
                             out_data, out_tag, out_err, e.data, e.tag, e.err);
                else n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Drive one input and hold it until accepted; queue its expected result if tracked.
    task automatic send(input logic [15:0] x, input logic [1:0] sel, input logic [3:0] tag,
                        input logic [15:0] exp_data, input logic exp_err, input bit track);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = x;
        in_sel   = sel;
        in_tag   = tag;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done    = 1;
                acc_cyc = cyc;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready stayed 0, want 1 within 200 cycles");
        end else if (track) begin
            sb.push_back({exp_data, tag, exp_err});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk);
            if (out_valid) at = cyc;
        end
        if (at < 0) begin
            n_total++;
            $display("FAIL out_timeout: out_valid stayed 0, want 1 within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the act_start cycle.
    task automatic wait_start(output int at);
        at = -1;
        for (int i = 0; i < 10 && at < 0; i++) begin
            @(negedge clk);
            if (act_start) at = cyc;
        end
        if (at < 0) begin
            n_total++;
            $display("FAIL start_timeout: act_start stayed 0, want 1 within 10 cycles");
        end
    endtask

    task automatic respond(input int lat, input logic [15:0] r);
        repeat (lat) @(posedge clk);
        #1;
        act_done   = 1'b1;
        act_result = r;
        @(posedge clk);
        #1;
        act_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if ({out_valid, out_data, out_tag, out_err} !== '0)
            $display("FAIL reset_out: got valid=%b data=%h tag=%h err=%b, want all 0",
                     out_valid, out_data, out_tag, out_err);
        else n_pass++;
        n_total++;
        if ({act_start, act_x, act_y, act_z, act_sel} !== '0)
            $display("FAIL reset_act: got start=%b x=%h y=%h z=%h sel=%b, want all 0",
                     act_start, act_x, act_y, act_z, act_sel);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        ext_reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_relu();
        logic [15:0] xs [3] = '{16'hFC00, 16'h0600, 16'h8123};
        logic [1:0]  ss [3] = '{2'b10, 2'b10, 2'b11};
        logic [15:0] es [3] = '{16'h0000, 16'h0600, 16'h8123};
        int st0 = start_cnt;
        int o;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(xs[i], ss[i], 4'(i + 1), es[i], 1'b0, 1);
            wait_out(10, o);
            n_total++;
            if (o - acc_cyc !== 2) $display("FAIL relu_latency[%0d]: got %0d want 2", i, o - acc_cyc);
            else n_pass++;
        end
        n_total++;
        if (start_cnt - st0 !== 0)
            $display("FAIL relu_no_start: got %0d act_start cycles want 0", start_cnt - st0);
        else n_pass++;
    endtask

    task automatic test_tanh();
        int st0 = start_cnt;
        int s, o;
        out_ready = 1'b1;
        send(16'h0200, 2'b01, 4'h3, 16'h01DB, 1'b0, 1);
        wait_start(s);
        n_total++;
        if ({act_z, act_x, act_y, act_sel} !== {16'h0200, 16'h04D4, 16'h0000, 2'b01})
            $display("FAIL tanh_seeds: got z=%h x=%h y=%h sel=%b, want z=0200 x=04d4 y=0000 sel=01",
                     act_z, act_x, act_y, act_sel);
        else n_pass++;
        respond(5, 16'h01DB);
        wait_out(20, o);
        n_total++;
        if (o - acc_cyc !== 8) $display("FAIL tanh_latency: got %0d want 8", o - acc_cyc);
        else n_pass++;
        n_total++;
        if (start_cnt - st0 !== 1)
            $display("FAIL tanh_one_start: got %0d act_start cycles want 1", start_cnt - st0);
        else n_pass++;
    endtask

    task automatic test_saturate();
        logic [15:0] xs [5] = '{16'h0800, 16'hF800, 16'hF800, 16'h0800, 16'h8000};
        logic [1:0]  ss [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        logic [15:0] es [5] = '{16'h0400, 16'h0000, 16'hFC00, 16'h0400, 16'hFC00};
        int st0 = start_cnt;
        int o;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(xs[i], ss[i], 4'(i + 4), es[i], 1'b0, 1);
            wait_out(10, o);
            n_total++;
            if (o - acc_cyc !== 3) $display("FAIL sat_latency[%0d]: got %0d want 3", i, o - acc_cyc);
            else n_pass++;
        end
        n_total++;
        if (start_cnt - st0 !== 0)
            $display("FAIL sat_no_start: got %0d act_start cycles want 0", start_cnt - st0);
        else n_pass++;
    endtask

    // |x| == CLAMP is in range and goes to the unit.
    task automatic test_clamp_edge();
        int s, o;
        out_ready = 1'b1;
        send(16'h0400, 2'b00, 4'h9, 16'h02EC, 1'b0, 1);
        wait_start(s);
        n_total++;
        if (s - acc_cyc !== 1) $display("FAIL edge_pos_issue: got start offset %0d want 1", s - acc_cyc);
        else n_pass++;
        respond(2, 16'h02EC);
        wait_out(20, o);
        n_total++;
        if (o - acc_cyc !== 5) $display("FAIL edge_pos_latency: got %0d want 5", o - acc_cyc);
        else n_pass++;
        send(16'hFC00, 2'b01, 4'hA, 16'hFD12, 1'b0, 1);
        wait_start(s);
        n_total++;
        if (act_z !== 16'hFC00) $display("FAIL edge_neg_z: got %h want fc00", act_z);
        else n_pass++;
        respond(1, 16'hFD12);
        wait_out(20, o);
        n_total++;
        if (o - acc_cyc !== 4) $display("FAIL edge_neg_latency: got %0d want 4", o - acc_cyc);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int s, o;
        bit bad = 0;
        out_ready = 1'b1;
        send(16'h0100, 2'b01, 4'h5, 16'h0000, 1'b1, 1);
        wait_start(s);
        wait_out(100, o);
        // Timeout fires TIMEOUT cycles after act_start, then PUSH and the FIFO add two cycles.
        n_total++;
        if (o - s !== TIMEOUT + 2)
            $display("FAIL timeout_latency: got %0d want %0d", o - s, TIMEOUT + 2);
        else n_pass++;
        act_done   = 1'b1;
        act_result = 16'h1234;
        @(posedge clk);
        #1;
        act_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid || act_start || !in_ready) bad = 1;
        end
        n_total++;
        if (bad !== 1'b0) $display("FAIL idle_spurious_done: got disturbance=%b want 0", bad);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full();
        bit  seen_ready = 0;
        bit  drained = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(16'(16'h0010 * (i + 1)), 2'b10, 4'(i + 8), 16'(16'h0010 * (i + 1)), 1'b0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({in_ready, out_valid} !== 2'b01)
            $display("FAIL full_flags: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'h0077;
        in_sel   = 2'b10;
        in_tag   = 4'hC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (in_ready) seen_ready = 1;
        end
        n_total++;
        if (seen_ready !== 1'b0) $display("FAIL full_blocks: got in_ready=1 while full want 0");
        else n_pass++;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h0077, 2'b10, 4'hC, 16'h0077, 1'b0, 1);
        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk);
            if (sb.size() == 0) drained = 1;
        end
        n_total++;
        if (sb.size() !== 0) $display("FAIL full_drain: got %0d pending want 0", sb.size());
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_wait();
        int  s;
        bit  bad = 0;
        out_ready = 1'b1;
        send(16'h0100, 2'b01, 4'hD, 16'h0000, 1'b0, 0);
        wait_start(s);
        repeat (3) @(posedge clk);
        #1;
        ext_reset_n = 1'b0;
        #1;
        n_total++;
        if ({act_start, out_valid, in_ready} !== 3'b000)
            $display("FAIL rst_wait_ctrl: got start=%b out_valid=%b in_ready=%b want 000",
                     act_start, out_valid, in_ready);
        else n_pass++;
        n_total++;
        if ({act_x, act_z, act_sel} !== '0)
            $display("FAIL rst_wait_seeds: got x=%h z=%h sel=%b want 0", act_x, act_z, act_sel);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL rst_hold_in_ready: got %b want 0", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        ext_reset_n = 1'b1;
        respond(1, 16'h7777);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || act_start) bad = 1;
        end
        n_total++;
        if (bad !== 1'b0) $display("FAIL late_done: got output or start=%b want 0", bad);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_relu();
        test_tanh();
        test_saturate();
        test_clamp_edge();
        test_timeout();
        test_full();
        test_reset_in_wait();
        n_total++;
        if (sb.size() !== 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
